// File: rtl/wm_pkg.sv
// Shared washing-machine encodings: panel mode codes and door switch levels.
// Used by the panel conditioner and washing_machine_top alike; no backpressure anywhere.
package wm_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL     = 2'd0,
      MODE_DELICATE   = 2'd1,
      MODE_HEAVY      = 2'd2,
      MODE_RINSE_ONLY = 2'd3
   } mode_e;

   localparam logic DOOR_CLOSED = 1'b1;
   localparam logic DOOR_OPEN   = 1'b0;

   // Mode button steps through the four programs and wraps RINSE_ONLY back to NORMAL.
   function automatic logic [1:0] mode_next(input logic [1:0] cur);
      mode_e nxt;
      case (cur)
         MODE_NORMAL:   nxt = MODE_DELICATE;
         MODE_DELICATE: nxt = MODE_HEAVY;
         MODE_HEAVY:    nxt = MODE_RINSE_ONLY;
         default:       nxt = MODE_NORMAL;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/wm_debounce.sv
// Synchronizer plus debounce filter for one raw panel level; stable moves SYNC_STAGES+DEBOUNCE_CYCLES
// edges after the raw change, rise/fall are one-cycle pulses on the flip edge; no backpressure.
module wm_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);
   import wm_pkg::*;

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         rise   <= 1'b0;
         fall   <= 1'b0;
         // Any matching sample restarts the count, so short glitches never accumulate.
         if (synced != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= synced;
               cnt    <= '0;
               rise   <= synced;
               fall   <= ~synced;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/wm_panel_input.sv
// Front-panel conditioner: debounced start pulse, mode selection, door level, lock drive and door fault.
// Start/mode act SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after a raw press; all outputs registered; no backpressure.
module wm_panel_input #(
   parameter int SYNC_STAGES      = 2,
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int LOCK_HOLD_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start_raw,
   input  logic       btn_mode_raw,
   input  logic       door_raw,
   input  logic       cycle_active,
   output logic       start_pause,
   output logic [1:0] mode_select,
   output logic       door_sensor,
   output logic       door_lock,
   output logic       door_fault
);
   import wm_pkg::*;

   localparam int            HW        = $clog2(LOCK_HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(LOCK_HOLD_CYCLES);

   logic start_rise;
   logic mode_rise;
   logic door_stable;
   logic door_fall;
   logic start_stable_unused;
   logic start_fall_unused;
   logic mode_stable_unused;
   logic mode_fall_unused;
   logic door_rise_unused;

   logic          cycle_active_q;
   logic [HW-1:0] hold;
   logic [HW-1:0] hold_nxt;

   wm_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_start (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_start_raw),
      .stable(start_stable_unused),
      .rise  (start_rise),
      .fall  (start_fall_unused)
   );

   wm_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_mode (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_mode_raw),
      .stable(mode_stable_unused),
      .rise  (mode_rise),
      .fall  (mode_fall_unused)
   );

   wm_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_door (
      .clk   (clk),
      .reset (reset),
      .raw   (door_raw),
      .stable(door_stable),
      .rise  (door_rise_unused),
      .fall  (door_fall)
   );

   // The debouncer's stable level is already a flop, so the door level is passed straight out.
   assign door_sensor = door_stable;

   always_comb begin
      hold_nxt = hold;
      if (cycle_active) begin
         hold_nxt = '0;
      end else if (cycle_active_q) begin
         hold_nxt = HOLD_LOAD;
      end else if (hold != '0) begin
         hold_nxt = hold - HW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_active_q <= 1'b0;
         hold           <= '0;
         door_lock      <= 1'b0;
         start_pause    <= 1'b0;
         mode_select    <= MODE_NORMAL;
         door_fault     <= 1'b0;
      end else begin
         cycle_active_q <= cycle_active;
         hold           <= hold_nxt;
         // Lock follows the next hold value so it releases exactly LOCK_HOLD_CYCLES+1 edges after the drop.
         door_lock      <= cycle_active | (hold_nxt != '0);
         start_pause    <= start_rise;
         if (mode_rise && !cycle_active) begin
            mode_select <= mode_next(mode_select);
         end
         if (door_fall && door_lock) begin
            door_fault <= 1'b1;
         end else if (start_rise && (door_sensor == DOOR_CLOSED) && !cycle_active) begin
            door_fault <= 1'b0;
         end
      end
   end

endmodule
